regfile_2r1w: RTL
=================

Name: regfile_2r1w

Overview:
Parametrised register file with two read ports and one write port. It is the next-generation general-purpose register storage for the datapath.
- Registered reads with 1-cycle latency and per-port valid.
- Write-first forwarding for same-cycle write/read to the same address.
- Optional hardwired-zero register 0.
- Clear sequencer that sweeps all entries to zero under a req/busy/done handshake.
- Sits between the decode/control unit and the ALU operand muxes.

Parameters:
DATA_W, 8, width of each register in bits
NUM_REGS, 4, number of entries (≥2; need not be a power of 2)
ADDR_W, $clog2(NUM_REGS), address width (derived; not to be overridden)
ZERO_REG, 0, 1 = entry 0 always reads 0 and ignores writes

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
we  in  1  write enable
waddr  in  ADDR_W  write address
wdata  in  DATA_W  write data
re_a  in  1  read request, port A
raddr_a  in  ADDR_W  read address, port A
rdata_a  out  DATA_W  read data, port A (registered)
rvalid_a  out  1  rdata_a valid, one cycle after re_a
re_b  in  1  read request, port B
raddr_b  in  ADDR_W  read address, port B
rdata_b  out  DATA_W  read data, port B (registered)
rvalid_b  out  1  rdata_b valid, one cycle after re_b
clr_req  in  1  single-cycle request to clear all entries
clr_busy  out  1  high while a clear sweep is in progress
clr_done  out  1  one-cycle pulse when a sweep completes
wr_err  out  1  one-cycle pulse: write dropped (busy, out of range, or to zero-reg)

Behaviour:
- Reset (rst_n low, async):
  - All entries are 0.
  - rdata_a/b, rvalid_a/b, clr_busy, clr_done and wr_err are all 0.
  - FSM goes to IDLE and the sweep counter to 0.
  - Reset mid-sweep aborts the sweep with no clr_done.
- Write: when we=1 at a clock edge, entry[waddr] <= wdata, subject to these exceptions:
  - waddr ≥ NUM_REGS: write is dropped and wr_err pulses next cycle.
  - ZERO_REG=1 and waddr=0: write is dropped and wr_err pulses.
  - clr_busy=1: write is dropped and wr_err pulses.
- Read: when re_x=1 at edge N, rdata_x and rvalid_x=1 are presented after edge N.
  - If re_x=0, rvalid_x=0 and rdata_x holds its last value.
  - raddr ≥ NUM_REGS returns 0 with rvalid=1.
  - ZERO_REG=1 and raddr=0 returns 0.
- Forwarding: accepted write and read in the same cycle to the same address returns wdata (write-first). This applies to both ports independently.
- Both ports may read the same address in the same cycle; both return identical data.
- Clear FSM:
  - IDLE: clr_req=1 goes to SWEEP with the counter at 0 and clr_busy=1 from the next cycle.
  - SWEEP: each cycle entry[counter] <= 0 and the counter increments.
    - When counter = NUM_REGS-1, that entry is cleared and the FSM goes to DONE.
  - DONE: clr_done=1 for one cycle and clr_busy=0, then return to IDLE.
  - Total: req at edge N, busy over edges N+1..N+NUM_REGS, done pulse after edge N+NUM_REGS+1.
  - clr_req while busy or in DONE is ignored; there is no queueing.
  - Reads during SWEEP return 0 regardless of address, with rvalid as normal.
- Simultaneous clr_req and we in IDLE: the write is accepted in that cycle and the sweep then clears it.
- The sweep counter is ADDR_W wide and must not wrap past NUM_REGS-1.

Decomposition:
- Shared header regfile_defs holds:
  - FSM state encodings: IDLE=2'b00, SWEEP=2'b01, DONE=2'b10.
  - A localparam for the zero value.
- Sub-module regfile_clear_fsm owns:
  - The state register and sweep counter.
  - Outputs clr_busy, clr_done, sweep_we and sweep_addr.
- The top level owns storage, read/forward muxes and wr_err.

Test Plan:
- Reset then read all addresses on A and B: rdata=0x00 and rvalid=1 one cycle after each re.
- Write 0xA5 to addr 2, then read addr 2 on A next cycle: rdata_a=0xA5. Same-cycle write 0x3C to addr 1 with read addr 1 on A and B: both return 0x3C.
- ZERO_REG=1: write 0xFF to addr 0, then read 0: returns 0x00 and wr_err pulses. NUM_REGS=3: write addr 3: wr_err=1, and a read of addr 3 returns 0x00.
- Fill entries with 0x11/0x22/0x33/0x44, then pulse clr_req:
  - clr_busy is high for exactly 4 cycles, then clr_done pulses once.
  - All entries then read 0x00.
  - A write attempted mid-sweep pulses wr_err and leaves the entry 0.
- Pulse clr_req twice during busy: still exactly one clr_done. Deassert rst_n mid-sweep: all outputs 0 immediately, with no clr_done after release.
- DATA_W=16, NUM_REGS=8: random write/read traffic on both ports is checked against a reference model, including forwarding collisions.

Source files
------------

// File: rtl/regfile_defs.sv
// Shared definitions for the 2R1W register file: clear-sweep state encodings and the reset/clear value.
// No logic, so no latency.
// No flow control of its own.
package regfile_defs;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SWEEP = 2'b01,
        DONE  = 2'b10
    } clr_state_e;

    localparam int unsigned ZERO_VAL = 0;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: once started by a request, it walks every entry index and drives a zero-write strobe for each one.
// Latency: busy rises 1 cycle after clr_req and stays high for NUM_REGS cycles; the done pulse comes 1 cycle after busy falls.
// Backpressure: clr_req is ignored while a sweep is busy or in its done cycle, and no request is queued.
module regfile_clear_fsm
    import regfile_defs::*;
#(
    parameter int NUM_REGS = 4,
    localparam int ADDR_W = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              sweep_we,
    output logic [ADDR_W-1:0] sweep_addr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

    clr_state_e        state;
    logic [ADDR_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state    <= SWEEP;
                        cnt      <= '0;
                        clr_busy <= 1'b1;
                    end
                end
                SWEEP: begin
                    // Stop on the last real entry, so a non-power-of-2 depth never walks into unused codes.
                    if (cnt == LAST) begin
                        state    <= DONE;
                        cnt      <= '0;
                        clr_busy <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    clr_done <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    clr_busy <= 1'b0;
                end
            endcase
        end
    end

    assign sweep_we   = (state == SWEEP);
    assign sweep_addr = cnt;

endmodule

// File: rtl/regfile_2r1w.sv
// 2-read/1-write register file with write-first forwarding, an optional hardwired-zero entry 0 and a sweeping clear.
// Latency: reads are registered, so data appears 1 cycle after re_x; a write is visible on the next edge, or in the same cycle through forwarding.
// Backpressure: none; writes made while clearing, out of range, or to the zero register are dropped and flagged on wr_err.
module regfile_2r1w
    import regfile_defs::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4,
    parameter bit ZERO_REG = 1'b0,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    output logic              rvalid_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              rvalid_b,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              wr_err
);

    localparam logic [DATA_W-1:0] ZERO_DAT = DATA_W'(ZERO_VAL);

    logic [DATA_W-1:0] mem [NUM_REGS];
    logic              sweep_we;
    logic [ADDR_W-1:0] sweep_addr;
    logic              wr_ok;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    regfile_clear_fsm #(.NUM_REGS(NUM_REGS)) u_clear_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_req    (clr_req),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr)
    );

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return 32'(addr) < NUM_REGS;
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return ZERO_REG && (addr == '0);
    endfunction

    assign wr_ok = we && !clr_busy && in_range(waddr) && !is_zero_reg(waddr);

    // Read path: the whole file reads as zero while a sweep is running, and an accepted write to the read address wins over storage.
    function automatic logic [DATA_W-1:0] read_mux(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = ZERO_DAT;
        if (!clr_busy && in_range(addr) && !is_zero_reg(addr)) begin
            if (wr_ok && (waddr == addr)) begin
                val = wdata;
            end else begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (addr == ADDR_W'(i)) val = mem[i];
                end
            end
        end
        return val;
    endfunction

    assign rd_a = read_mux(raddr_a);
    assign rd_b = read_mux(raddr_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= ZERO_DAT;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (sweep_we && (sweep_addr == ADDR_W'(i))) begin
                    mem[i] <= ZERO_DAT;
                end else if (wr_ok && (waddr == ADDR_W'(i))) begin
                    mem[i] <= wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_a  <= ZERO_DAT;
            rdata_b  <= ZERO_DAT;
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            rvalid_a <= re_a;
            rvalid_b <= re_b;
            if (re_a) rdata_a <= rd_a;
            if (re_b) rdata_b <= rd_b;
            wr_err <= we && !wr_ok;
        end
    end

endmodule
